// File: rtl/apb_soc_pkg.sv
// SoC peripheral APB map shared by the peripheral arbiter and its address decoder.
// Rules are listed in peripheral index order; the index doubles as the slave select bit.
package apb_soc_pkg;

  localparam int unsigned NUM_APB_SLAVES = 7;

  localparam logic [31:0] FLL_BASE      = 32'h1A10_0000;
  localparam logic [31:0] HYAXICFG_BASE = 32'h1A10_1000;
  localparam logic [31:0] ADVTIMER_BASE = 32'h1A10_3000;
  localparam logic [31:0] PADFRAME_BASE = 32'h1A10_4000;
  localparam logic [31:0] GPIOS_BASE    = 32'h1A10_5000;
  localparam logic [31:0] SOCCTRL_BASE  = 32'h1A10_6000;
  localparam logic [31:0] UDMA_BASE     = 32'h1A20_0000;

  localparam logic [31:0] FLL_LEN      = 32'h0000_1000;
  localparam logic [31:0] HYAXICFG_LEN = 32'h0000_1000;
  localparam logic [31:0] ADVTIMER_LEN = 32'h0000_1000;
  localparam logic [31:0] PADFRAME_LEN = 32'h0000_1000;
  localparam logic [31:0] GPIOS_LEN    = 32'h0000_1000;
  localparam logic [31:0] SOCCTRL_LEN  = 32'h0000_1000;
  localparam logic [31:0] UDMA_LEN     = 32'h0002_2000;

  typedef struct packed {
    logic [2:0]  idx;
    logic [31:0] base;
    logic [31:0] length;
  } addr_map_rule_t;

  localparam addr_map_rule_t ADDR_MAP [NUM_APB_SLAVES] = '{
    '{3'd0, FLL_BASE,      FLL_LEN},
    '{3'd1, HYAXICFG_BASE, HYAXICFG_LEN},
    '{3'd2, ADVTIMER_BASE, ADVTIMER_LEN},
    '{3'd3, PADFRAME_BASE, PADFRAME_LEN},
    '{3'd4, GPIOS_BASE,    GPIOS_LEN},
    '{3'd5, SOCCTRL_BASE,  SOCCTRL_LEN},
    '{3'd6, UDMA_BASE,     UDMA_LEN}
  };

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    ERR
  } apb_state_e;

  // Half-open range test; the end address is formed in 32-bit unsigned arithmetic.
  function automatic logic addr_in_rule(input logic [31:0] addr, input addr_map_rule_t rule);
    logic [31:0] limit;
    limit = rule.base + rule.length;
    return (addr >= rule.base) && (addr < limit);
  endfunction

endpackage

// File: rtl/apb_soc_addr_decode.sv
// Combinational search of the peripheral map; the lowest matching rule index wins.
module apb_soc_addr_decode
  import apb_soc_pkg::*;
(
  input  logic [31:0] addr,
  output logic [2:0]  idx,
  output logic        match
);

  always_comb begin
    idx   = '0;
    match = 1'b0;
    for (int i = NUM_APB_SLAVES - 1; i >= 0; i--) begin
      if (addr_in_rule(addr, ADDR_MAP[i])) begin
        idx   = ADDR_MAP[i].idx;
        match = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_soc_periph_arbiter.sv
// Two-requester round-robin APB arbiter for the SoC peripheral bus, with address
// decode, a SETUP/ACCESS sequencer and a watchdog that aborts hung accesses.
module apb_soc_periph_arbiter
  import apb_soc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned NUM_MST        = 2,
  parameter int unsigned NUM_SLV        = NUM_APB_SLAVES
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_MST-1:0]         m_psel_i,
  input  logic [NUM_MST-1:0]         m_penable_i,
  input  logic [NUM_MST-1:0][31:0]   m_paddr_i,
  input  logic [NUM_MST-1:0]         m_pwrite_i,
  input  logic [NUM_MST-1:0][31:0]   m_pwdata_i,
  output logic [NUM_MST-1:0][31:0]   m_prdata_o,
  output logic [NUM_MST-1:0]         m_pready_o,
  output logic [NUM_MST-1:0]         m_pslverr_o,
  output logic [NUM_SLV-1:0]         s_psel_o,
  output logic                       s_penable_o,
  output logic                       s_pwrite_o,
  output logic [31:0]                s_paddr_o,
  output logic [31:0]                s_pwdata_o,
  input  logic [NUM_SLV-1:0][31:0]   s_prdata_i,
  input  logic [NUM_SLV-1:0]         s_pready_i,
  input  logic [NUM_SLV-1:0]         s_pslverr_i
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  apb_state_e       state_q, state_d;
  logic             last_q, last_d;
  logic             gnt_q, gnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             write_q, write_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             arb_sel;
  logic [2:0]       dec_idx;
  logic             dec_match;
  logic [NUM_SLV-1:0] idx_oh;
  logic             slv_ready;
  logic             slv_err;
  logic [31:0]      slv_rdata;

  // A lone requester always wins; on a tie the one not served last time goes first.
  assign arb_sel = (&m_psel_i) ? ~last_q : m_psel_i[1];

  apb_soc_addr_decode u_decode (
    .addr  (m_paddr_i[arb_sel]),
    .idx   (dec_idx),
    .match (dec_match)
  );

  always_comb begin
    idx_oh    = '0;
    slv_ready = 1'b0;
    slv_err   = 1'b0;
    slv_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (idx_q == 3'(i)) begin
        idx_oh[i] = 1'b1;
        slv_ready = s_pready_i[i];
        slv_err   = s_pslverr_i[i];
        slv_rdata = s_prdata_i[i];
      end
    end
  end

  assign s_paddr_o  = addr_q;
  assign s_pwdata_o = wdata_q;
  assign s_pwrite_o = write_q;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    s_psel_o    = '0;
    s_penable_o = 1'b0;
    m_pready_o  = '0;
    m_pslverr_o = '0;
    m_prdata_o  = '0;

    unique case (state_q)
      IDLE: begin
        if (|m_psel_i) begin
          gnt_d   = arb_sel;
          last_d  = arb_sel;
          addr_d  = m_paddr_i[arb_sel];
          wdata_d = m_pwdata_i[arb_sel];
          write_d = m_pwrite_i[arb_sel];
          idx_d   = dec_idx;
          cnt_d   = '0;
          state_d = dec_match ? SETUP : ERR;
        end
      end
      SETUP: begin
        s_psel_o = idx_oh;
        state_d  = ACCESS;
      end
      ACCESS: begin
        s_psel_o    = idx_oh;
        s_penable_o = 1'b1;
        // Slave completion takes priority over a watchdog expiry in the same cycle.
        if (slv_ready) begin
          m_pready_o[gnt_q]  = 1'b1;
          m_pslverr_o[gnt_q] = slv_err;
          m_prdata_o[gnt_q]  = slv_rdata;
          state_d            = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          m_pready_o[gnt_q]  = 1'b1;
          m_pslverr_o[gnt_q] = 1'b1;
          cnt_d              = cnt_q + CNT_W'(1);
          state_d            = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ERR: begin
        m_pready_o[gnt_q]  = 1'b1;
        m_pslverr_o[gnt_q] = 1'b1;
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset drops any in-flight transfer silently; last=1 lets requester 0 win the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar m = 0; m < NUM_MST; m++) begin : g_req_chk
    a_penable_needs_psel : assert property (@(posedge clk_i) disable iff (rst_i)
      m_penable_i[m] |-> m_psel_i[m]);
  end

endmodule

// File: tb/tb_apb_soc_periph_arbiter.sv
// Self-checking bench for apb_soc_periph_arbiter: directed vector table, hand-written
// corner sequences and randomized traffic against a transaction-level reference model.
module tb_apb_soc_periph_arbiter;

  localparam int TO = 4;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [1:0]       m_psel_i, m_penable_i, m_pwrite_i;
  logic [1:0][31:0] m_paddr_i, m_pwdata_i, m_prdata_o;
  logic [1:0]       m_pready_o, m_pslverr_o;
  logic [6:0]       s_psel_o;
  logic             s_penable_o, s_pwrite_o;
  logic [31:0]      s_paddr_o, s_pwdata_o;
  logic [6:0][31:0] s_prdata_i;
  logic [6:0]       s_pready_i, s_pslverr_i;

  int errors = 0;
  int checks = 0;

  // slave behaviour: ready after slv_wait ACCESS cycles (>= TO means never in time)
  int          slv_wait [7];
  logic [31:0] slv_rdata[7];
  logic        slv_err  [7];
  int          acc_cnt;

  localparam logic [31:0] MAP_BASE[7] = '{32'h1A10_0000, 32'h1A10_1000, 32'h1A10_3000,
    32'h1A10_4000, 32'h1A10_5000, 32'h1A10_6000, 32'h1A20_0000};
  localparam logic [31:0] MAP_LEN[7] = '{32'h1000, 32'h1000, 32'h1000, 32'h1000,
    32'h1000, 32'h1000, 32'h22000};

  int          got_lat  [2];
  logic [31:0] got_rdata[2];
  logic        got_err  [2];
  logic [6:0]  got_psel;
  logic [31:0] cap_addr, cap_wdata;
  logic        cap_write, unstable, spurious;
  int          model_last;

  apb_soc_periph_arbiter #(.TIMEOUT_CYCLES(TO), .NUM_MST(2), .NUM_SLV(7)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_psel_i(m_psel_i), .m_penable_i(m_penable_i), .m_paddr_i(m_paddr_i),
    .m_pwrite_i(m_pwrite_i), .m_pwdata_i(m_pwdata_i), .m_prdata_o(m_prdata_o),
    .m_pready_o(m_pready_o), .m_pslverr_o(m_pslverr_o),
    .s_psel_o(s_psel_o), .s_penable_o(s_penable_o), .s_pwrite_o(s_pwrite_o),
    .s_paddr_o(s_paddr_o), .s_pwdata_o(s_pwdata_o), .s_prdata_i(s_prdata_i),
    .s_pready_i(s_pready_i), .s_pslverr_i(s_pslverr_i)
  );

  always #5 clk_i = ~clk_i;

  always_comb begin
    for (int s = 0; s < 7; s++) begin
      s_pready_i[s]  = s_psel_o[s] & s_penable_o & (acc_cnt >= slv_wait[s]);
      s_prdata_i[s]  = slv_rdata[s];
      s_pslverr_i[s] = slv_err[s];
    end
  end

  always @(posedge clk_i) begin
    if (rst_i) acc_cnt <= 0;
    else if (s_penable_o && (s_psel_o != 0) && ((s_pready_i & s_psel_o) == 0)) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  // ---------------- reference model (transaction level) ----------------
  function automatic int refDecode(input logic [31:0] a);
    logic [31:0] off;
    for (int s = 0; s < 7; s++) begin
      off = a - MAP_BASE[s];
      if (off < MAP_LEN[s]) return s;
    end
    return -1;
  endfunction

  function automatic int refLat(input logic [31:0] a);
    int s;
    s = refDecode(a);
    if (s < 0) return 1;
    if (slv_wait[s] < TO) return 2 + slv_wait[s];
    return TO + 1;
  endfunction

  function automatic logic [31:0] refRdata(input logic [31:0] a);
    int s;
    s = refDecode(a);
    if (s < 0 || slv_wait[s] >= TO) return 32'h0;
    return slv_rdata[s];
  endfunction

  function automatic logic refErr(input logic [31:0] a);
    int s;
    s = refDecode(a);
    if (s < 0 || slv_wait[s] >= TO) return 1'b1;
    return slv_err[s];
  endfunction

  function automatic logic [31:0] randAddr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) return MAP_BASE[r] + (($urandom % MAP_LEN[r]) & 32'hFFFF_FFFC);
    if (r == 7) return 32'h1A10_2000 + ($urandom_range(0, 32'hFFF) & 32'hFFC);
    if (r == 8) return 32'h1A22_2000 + ($urandom_range(0, 32'hFF) & 32'hFC);
    return $urandom;
  endfunction

  // ---------------- tasks ----------------
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic cfgSlave(input int s, input int w, input logic [31:0] rd, input logic e);
    slv_wait[s]  = w;
    slv_rdata[s] = rd;
    slv_err[s]   = e;
  endtask

  task automatic applyStimulus(input int m, input logic [31:0] a, input logic wr, input logic [31:0] wd);
    m_paddr_i[m]  = a;
    m_pwrite_i[m] = wr;
    m_pwdata_i[m] = wd;
  endtask

  // Raise the requests in mask, collect each response, drop psel right after pready.
  task automatic runReq(input logic [1:0] mask);
    logic [1:0] pend;
    int cyc;
    pend = mask; cyc = 0;
    got_psel = '0; unstable = 1'b0; spurious = 1'b0;
    cap_addr = '0; cap_wdata = '0; cap_write = 1'b0;
    for (int m = 0; m < 2; m++) begin got_lat[m] = -1; got_rdata[m] = 'x; got_err[m] = 1'bx; end
    m_psel_i = mask;
    while (pend != 0 && cyc < 600) begin
      @(negedge clk_i);
      cyc++;
      got_psel |= s_psel_o;
      if ($countones(s_psel_o) > 1) unstable = 1'b1;
      if (s_psel_o != 0 && !s_penable_o) begin
        cap_addr = s_paddr_o; cap_wdata = s_pwdata_o; cap_write = s_pwrite_o;
      end else if (s_psel_o != 0 && (s_paddr_o !== cap_addr || s_pwdata_o !== cap_wdata ||
                                     s_pwrite_o !== cap_write)) begin
        unstable = 1'b1;
      end
      if ((m_pready_o & ~pend) != 0) spurious = 1'b1;
      for (int m = 0; m < 2; m++) begin
        if (pend[m] && m_pready_o[m]) begin
          got_lat[m]   = cyc;
          got_rdata[m] = m_prdata_o[m];
          got_err[m]   = m_pslverr_o[m];
          pend[m]      = 1'b0;
          m_psel_i[m]  = 1'b0;
        end
      end
    end
    if (pend != 0) begin
      checks++; errors++;
      $display("[TB] FAIL response_timeout: pending=%b after %0d cycles, required none", pend, cyc);
      m_psel_i = '0;
    end
  endtask

  typedef struct {
    int          m;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    int          slv;
    int          waitc;
    logic [31:0] rdata;
    logic        serr;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [6:0]  exp_psel;
  } vec_t;

  vec_t vec[12];

  initial begin
    int n, cyc, prev, exp_g, first, second;
    logic [1:0] mask;
    logic [31:0] ra[2];
    logic seen;

    vec[0]  = '{0, 32'h1A10_5004, 1'b1, 32'hDEAD_BEEF, 4, 0,   32'h4444_0000, 1'b0, 2, 32'h4444_0000, 1'b0, 7'b001_0000};
    vec[1]  = '{1, 32'h1A10_2000, 1'b0, 32'h0,        -1, 0,   32'h0,         1'b0, 1, 32'h0,         1'b1, 7'b000_0000};
    vec[2]  = '{1, 32'h1A22_2000, 1'b0, 32'h0,        -1, 0,   32'h0,         1'b0, 1, 32'h0,         1'b1, 7'b000_0000};
    vec[3]  = '{0, 32'h1A22_1FFC, 1'b0, 32'h0,         6, 0,   32'h6666_0001, 1'b0, 2, 32'h6666_0001, 1'b0, 7'b100_0000};
    vec[4]  = '{1, 32'h1A10_3FFC, 1'b0, 32'h0,         2, 1,   32'h2222_0002, 1'b0, 3, 32'h2222_0002, 1'b0, 7'b000_0100};
    vec[5]  = '{0, 32'h1A10_4000, 1'b0, 32'h0,         3, 255, 32'h3333_0003, 1'b0, 5, 32'h0,         1'b1, 7'b000_1000};
    vec[6]  = '{0, 32'h1A10_6008, 1'b1, 32'h1234_5678, 5, 3,   32'h5555_0003, 1'b0, 5, 32'h5555_0003, 1'b0, 7'b010_0000};
    vec[7]  = '{1, 32'h1A20_0010, 1'b0, 32'h0,         6, 2,   32'h6666_0002, 1'b1, 4, 32'h6666_0002, 1'b1, 7'b100_0000};
    vec[8]  = '{1, 32'h1A10_1000, 1'b1, 32'hCAFE_0001, 1, 0,   32'h1111_0000, 1'b1, 2, 32'h1111_0000, 1'b1, 7'b000_0010};
    vec[9]  = '{0, 32'h1A0F_FFFC, 1'b0, 32'h0,        -1, 0,   32'h0,         1'b0, 1, 32'h0,         1'b1, 7'b000_0000};
    vec[10] = '{0, 32'h1A10_0FFC, 1'b0, 32'h0,         0, 0,   32'hF0F0_0F0F, 1'b0, 2, 32'hF0F0_0F0F, 1'b0, 7'b000_0001};
    vec[11] = '{1, 32'h1A10_7000, 1'b0, 32'h0,        -1, 0,   32'h0,         1'b0, 1, 32'h0,         1'b1, 7'b000_0000};

    for (int s = 0; s < 7; s++) cfgSlave(s, 0, 32'h0, 1'b0);
    rst_i = 1'b1; m_psel_i = '0; m_penable_i = '0; m_pwrite_i = '0;
    m_paddr_i = '0; m_pwdata_i = '0;
    model_last = 1;

    // reset state
    repeat (3) @(negedge clk_i);
    checkOutput("rst_m_pready",  32'(m_pready_o), 0);
    checkOutput("rst_m_pslverr", 32'(m_pslverr_o), 0);
    checkOutput("rst_m_prdata",  m_prdata_o[0] | m_prdata_o[1], 0);
    checkOutput("rst_s_psel",    32'(s_psel_o), 0);
    checkOutput("rst_s_ctrl",    32'({s_penable_o, s_pwrite_o}), 0);
    checkOutput("rst_s_paddr",   s_paddr_o, 0);
    checkOutput("rst_s_pwdata",  s_pwdata_o, 0);
    rst_i = 1'b0;

    // simultaneous requests out of reset: requester 0 first, then requester 1
    cfgSlave(0, 0, 32'hA0A0_0000, 1'b0);
    cfgSlave(6, 0, 32'hB6B6_0006, 1'b0);
    applyStimulus(0, 32'h1A10_0000, 1'b0, 32'h0);
    applyStimulus(1, 32'h1A21_0000, 1'b0, 32'h0);
    runReq(2'b11);
    checkOutput("tie_lat0",   32'(got_lat[0]), 2);
    checkOutput("tie_lat1",   32'(got_lat[1]), 5);
    checkOutput("tie_rdata0", got_rdata[0], 32'hA0A0_0000);
    checkOutput("tie_rdata1", got_rdata[1], 32'hB6B6_0006);
    checkOutput("tie_err",    32'({got_err[1], got_err[0]}), 0);
    checkOutput("tie_psel",   32'(got_psel), 32'b100_0001);
    model_last = 1;
    @(negedge clk_i);

    // directed vector table
    for (int i = 0; i < 12; i++) begin
      if (vec[i].slv >= 0) cfgSlave(vec[i].slv, vec[i].waitc, vec[i].rdata, vec[i].serr);
      applyStimulus(vec[i].m, vec[i].addr, vec[i].wr, vec[i].wdata);
      runReq(2'b01 << vec[i].m);
      checkOutput($sformatf("vec%0d_lat", i),   32'(got_lat[vec[i].m]), 32'(vec[i].exp_lat));
      checkOutput($sformatf("vec%0d_rdata", i), got_rdata[vec[i].m], vec[i].exp_rdata);
      checkOutput($sformatf("vec%0d_err", i),   32'(got_err[vec[i].m]), 32'(vec[i].exp_err));
      checkOutput($sformatf("vec%0d_psel", i),  32'(got_psel), 32'(vec[i].exp_psel));
      checkOutput($sformatf("vec%0d_bus_ok", i), 32'({unstable, spurious}), 0);
      if (vec[i].exp_psel != 0) begin
        checkOutput($sformatf("vec%0d_paddr", i),  cap_addr, vec[i].addr);
        checkOutput($sformatf("vec%0d_pwdata", i), cap_wdata, vec[i].wdata);
        checkOutput($sformatf("vec%0d_pwrite", i), 32'(cap_write), 32'(vec[i].wr));
      end
      @(negedge clk_i);
      checkOutput($sformatf("vec%0d_idle_sel", i), 32'({s_psel_o, s_penable_o}), 0);
      model_last = vec[i].m;
    end

    // reset pulsed while a hung access sits in ACCESS
    cfgSlave(3, 255, 32'h3333_3333, 1'b0);
    applyStimulus(0, 32'h1A10_4010, 1'b1, 32'h5A5A_5A5A);
    m_psel_i = 2'b01;
    @(negedge clk_i);
    @(negedge clk_i);
    checkOutput("rstacc_in_access", 32'({s_psel_o, s_penable_o}), 32'b0001000_1);
    rst_i = 1'b1; m_psel_i = '0;
    @(negedge clk_i);
    rst_i = 1'b0;
    checkOutput("rstacc_m_out",  32'({m_pready_o, m_pslverr_o}), 0);
    checkOutput("rstacc_prdata", m_prdata_o[0] | m_prdata_o[1], 0);
    checkOutput("rstacc_s_ctrl", 32'({s_psel_o, s_penable_o, s_pwrite_o}), 0);
    checkOutput("rstacc_s_bus",  s_paddr_o | s_pwdata_o, 0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk_i);
      if (m_pready_o != 0 || s_psel_o != 0) seen = 1'b1;
    end
    checkOutput("rstacc_no_late_resp", 32'(seen), 0);
    model_last = 1;

    // continuous requests from both sides alternate 0,1,0,1...
    cfgSlave(4, 0, 32'h4444_4444, 1'b0);
    cfgSlave(5, 0, 32'h5555_5555, 1'b0);
    applyStimulus(0, 32'h1A10_5000, 1'b0, 32'h0);
    applyStimulus(1, 32'h1A10_6000, 1'b1, 32'h0101_0101);
    m_psel_i = 2'b11;
    n = 0; cyc = 0; prev = 0;
    while (n < 20 && cyc < 200) begin
      @(negedge clk_i);
      cyc++;
      if (m_pready_o != 0) begin
        exp_g = (model_last == 1) ? 0 : 1;
        checkOutput($sformatf("alt%0d_grant", n), 32'(m_pready_o), 32'(1) << exp_g);
        checkOutput($sformatf("alt%0d_interval", n), 32'(cyc - prev), (n == 0) ? 2 : 3);
        model_last = exp_g;
        prev = cyc;
        n++;
        if (n == 20) m_psel_i = '0;
      end
    end
    if (n < 20) begin
      checks++; errors++;
      $display("[TB] FAIL alt_progress: got %0d transfers, required 20", n);
      m_psel_i = '0;
    end
    @(negedge clk_i);

    // randomized traffic against the reference model
    for (int t = 0; t < 40; t++) begin
      for (int s = 0; s < 7; s++) cfgSlave(s, $urandom_range(0, 5), $urandom, 1'($urandom_range(0, 1)));
      mask = 2'($urandom_range(1, 3));
      for (int m = 0; m < 2; m++) begin
        ra[m] = randAddr();
        applyStimulus(m, ra[m], 1'($urandom_range(0, 1)), $urandom);
      end
      runReq(mask);
      first  = (mask == 2'b11) ? ((model_last == 1) ? 0 : 1) : (mask[1] ? 1 : 0);
      second = 1 - first;
      checkOutput($sformatf("rnd%0d_lat_first", t),   32'(got_lat[first]), 32'(refLat(ra[first])));
      checkOutput($sformatf("rnd%0d_rdata_first", t), got_rdata[first], refRdata(ra[first]));
      checkOutput($sformatf("rnd%0d_err_first", t),   32'(got_err[first]), 32'(refErr(ra[first])));
      if (mask == 2'b11) begin
        checkOutput($sformatf("rnd%0d_lat_second", t),
                    32'(got_lat[second]), 32'(refLat(ra[first]) + 1 + refLat(ra[second])));
        checkOutput($sformatf("rnd%0d_rdata_second", t), got_rdata[second], refRdata(ra[second]));
        checkOutput($sformatf("rnd%0d_err_second", t),   32'(got_err[second]), 32'(refErr(ra[second])));
        model_last = second;
      end else begin
        model_last = first;
      end
      checkOutput($sformatf("rnd%0d_bus_ok", t), 32'({unstable, spurious}), 0);
      @(negedge clk_i);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
